sdram_init_monitor: RTL

Synthesizable, parametrised monitor for the SDRAM controller's power-up initialisation sequence. It passively samples the SDRAM command pins and sdr_init_done on sdram_clk and checks:
- power-up wait,
- PRECHARGE,
- N x AUTO REFRESH with tRFC spacing,
- LOAD MODE REGISTER,
- init-done, with tRP/tMRD timing.

It reports pass/fail with a latched error code. It sits beside the DUV in the testbench top and can also be left in an FPGA build as a bring-up checker.

---
 rtl/sdram_init_monitor.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/sdram_init_monitor.sv
// Passive checker for the SDRAM power-up initialisation sequence.
// It reports pass, or the first violation code, from the command pins and the init-done flag.
module sdram_init_monitor #(
  parameter int CNT_W       = 16,
  parameter int P_PWRUP_CYC = 500,
  parameter int P_TRP       = 2,
  parameter int P_TRFC      = 7,
  parameter int P_NUM_AREF  = 2,
  parameter int P_TMRD      = 2,
  parameter int P_DONE_MAX  = 16,
  parameter int P_TIMEOUT   = 1024
) (
  input  logic       sdram_clk,
  input  logic       sdram_resetn,
  input  logic       chk_clr,
  input  logic       sdr_cke,
  input  logic       sdr_cs_n,
  input  logic       sdr_ras_n,
  input  logic       sdr_cas_n,
  input  logic       sdr_we_n,
  input  logic       sdr_init_done,
  output logic       chk_busy,
  output logic       chk_pass,
  output logic       chk_fail,
  output logic [3:0] chk_err_code,
  output logic [7:0] chk_aref_cnt,
  output logic [2:0] chk_state
);

  typedef enum logic [2:0] {
    S_WAIT_PWRUP = 3'd0,
    S_TRP        = 3'd1,
    S_AREF       = 3'd2,
    S_TMRD       = 3'd3,
    S_PASS       = 3'd4,
    S_FAIL       = 3'd5
  } state_t;

  typedef enum logic [2:0] {C_NOP, C_PRE, C_AREF, C_LMR, C_ILL} cmd_t;

  localparam logic [CNT_W-1:0] PWRUP    = CNT_W'(P_PWRUP_CYC);
  localparam logic [CNT_W-1:0] TRP      = CNT_W'(P_TRP);
  localparam logic [CNT_W-1:0] TRFC     = CNT_W'(P_TRFC);
  localparam logic [CNT_W-1:0] TMRD     = CNT_W'(P_TMRD);
  localparam logic [CNT_W-1:0] DONE_MAX = CNT_W'(P_DONE_MAX);
  localparam logic [CNT_W-1:0] TIMEOUT  = CNT_W'(P_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [7:0]       NUM_AREF = 8'(P_NUM_AREF);

  state_t           state, nxt_state;
  cmd_t             cmd;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       aref_cnt;
  logic [3:0]       err_code, err_nxt;
  logic             busy_q, aref_load, aref_inc;
  logic             e1, e2, e3, e5, e6, e7, e8, e9, e10;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    cmd = C_ILL;
    if (sdr_cs_n || ({sdr_ras_n, sdr_cas_n, sdr_we_n} == 3'b111)) cmd = C_NOP;
    else begin
      case ({sdr_ras_n, sdr_cas_n, sdr_we_n})
        3'b010:  cmd = C_PRE;
        3'b001:  cmd = C_AREF;
        3'b000:  cmd = C_LMR;
        default: cmd = C_ILL;
      endcase
    end
  end

  always_comb begin
    e1  = (state == S_WAIT_PWRUP) && (cmd == C_PRE) && (cnt < PWRUP);
    e2  = (state == S_TRP) && (cmd == C_AREF) && (cnt < TRP);
    e3  = (state == S_AREF) && ((cmd == C_AREF) || (cmd == C_LMR)) && (cnt < TRFC);
    e5  = ((state == S_WAIT_PWRUP) && (cmd != C_NOP) && (cmd != C_PRE))
       || ((state == S_TRP) && (cmd != C_NOP) && (cmd != C_AREF))
       || ((state == S_AREF) && ((cmd == C_PRE) || (cmd == C_ILL)))
       || ((state == S_TMRD) && (cmd != C_NOP));
    e6  = (state == S_AREF) && (cmd == C_LMR) && (aref_cnt < NUM_AREF);
    e7  = (sdr_init_done && ((state == S_WAIT_PWRUP) || (state == S_TRP) || (state == S_AREF)))
       || ((state == S_TMRD) && sdr_init_done && (cnt < TMRD));
    // A late init-done is reported the same way as a missing one.
    e8  = (state == S_TMRD) && (cnt > DONE_MAX);
    e9  = ((state == S_TRP) || (state == S_AREF) || (state == S_TMRD)) && !sdr_cke;
    e10 = ((state == S_TRP) || (state == S_AREF)) && (cnt > TIMEOUT);

    err_nxt = 4'd0;
    if      (e1)  err_nxt = 4'd1;
    else if (e2)  err_nxt = 4'd2;
    else if (e3)  err_nxt = 4'd3;
    else if (e5)  err_nxt = 4'd5;
    else if (e6)  err_nxt = 4'd6;
    else if (e7)  err_nxt = 4'd7;
    else if (e8)  err_nxt = 4'd8;
    else if (e9)  err_nxt = 4'd9;
    else if (e10) err_nxt = 4'd10;
  end

  always_comb begin
    nxt_state = state;
    aref_load = 1'b0;
    aref_inc  = 1'b0;
    if (chk_clr) begin
      nxt_state = S_WAIT_PWRUP;
    end else if (err_nxt != 4'd0) begin
      nxt_state = S_FAIL;
    end else begin
      case (state)
        S_WAIT_PWRUP: if (cmd == C_PRE) nxt_state = S_TRP;
        S_TRP: if (cmd == C_AREF) begin
          nxt_state = S_AREF;
          aref_load = 1'b1;
        end
        S_AREF: begin
          if (cmd == C_AREF) aref_inc  = 1'b1;
          if (cmd == C_LMR)  nxt_state = S_TMRD;
        end
        S_TMRD: if (sdr_init_done) nxt_state = S_PASS;
        default: nxt_state = state;
      endcase
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments, so every register sees pre-edge values.
  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) state <= S_WAIT_PWRUP;
    else               state <= nxt_state;
  end

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      cnt      <= '0;
      aref_cnt <= '0;
      err_code <= '0;
      busy_q   <= 1'b0;
    end else if (chk_clr) begin
      cnt      <= '0;
      aref_cnt <= '0;
      err_code <= '0;
      busy_q   <= 1'b1;
    end else begin
      if (cmd != C_NOP)       cnt <= CNT_W'(1);
      else if (cnt < CNT_MAX) cnt <= cnt + 1'b1;
      if (aref_load)                          aref_cnt <= 8'd1;
      else if (aref_inc && aref_cnt != 8'hFF) aref_cnt <= aref_cnt + 8'd1;
      if (err_nxt != 4'd0) err_code <= err_nxt;
      busy_q <= (nxt_state != S_PASS) && (nxt_state != S_FAIL);
    end
  end

  always_comb begin
    chk_busy     = busy_q;
    chk_pass     = (state == S_PASS);
    chk_fail     = (state == S_FAIL);
    chk_err_code = err_code;
    chk_aref_cnt = aref_cnt;
    chk_state    = state;
  end

endmodule
